led_pwm_uart: RTL and testbench
===============================

LED_PWM_UART -- requirements
Module: led_pwm_uart

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division, at least 4.
REQ-003 SHALL have parameter N_LEDS, default 24, LED channel count, range 1..254.
REQ-004 SHALL have parameter PWM_BITS, default 8, duty and PWM counter width, range 1..8.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port rx, input, 1 bit: UART receive, 8N1, idle high, asynchronous to clk.
REQ-008 SHALL have port tx, input/output direction output, 1 bit: UART transmit, 8N1, idle high.
REQ-009 SHALL have port leds, output, N_LEDS bits: per-channel PWM output, 1 = lit.

Function
REQ-010 SHALL pass rx through a 2-flop synchroniser (reset value 1) before any use.
REQ-011 Receiver SHALL detect start on a synchronised falling edge, re-sample at CLKS_PER_BIT/2, and abort to idle if the line is high there.
REQ-012 Receiver SHALL sample 8 data bits LSB first at CLKS_PER_BIT spacing, then the stop bit; stop = 0 means framing error, byte discarded, no parser event.
REQ-013 Parser SHALL have states IDX and VAL; it resets to IDX.
REQ-014 In IDX, a byte < N_LEDS or equal to 0xFF SHALL be latched as target and move the parser to VAL.
REQ-015 In IDX, any other byte SHALL queue NAK (0x15) and keep the parser in IDX.
REQ-016 In VAL, a byte SHALL write its low PWM_BITS bits to duty[target], or to every duty if target = 0xFF, queue ACK (0x06), and return the parser to IDX.
REQ-017 In VAL, if no byte completes within 32*CLKS_PER_BIT clocks of entering VAL, the parser SHALL return to IDX with no write and no response.
REQ-018 PWM counter SHALL be free-running, PWM_BITS wide, +1 per clk, wrapping from all-ones to 0.
REQ-019 Each channel SHALL use a shadow duty, loaded from duty on the cycle the counter wraps to 0; duty writes are never visible mid-period.
REQ-020 leds[i] SHALL be a register equal to (shadow[i] > counter); duty 0 = always off, all-ones = on for (2^PWM_BITS - 1) of 2^PWM_BITS cycles.
REQ-021 Transmitter SHALL send start bit, 8 data bits LSB first, and stop bit, each CLKS_PER_BIT clocks, with tx registered.
REQ-022 A response queued while the transmitter is idle SHALL start its start bit on the next clock.
REQ-023 A response queued while the transmitter is busy SHALL be held in a 1-deep pending slot; a later response overwrites the pending one.
REQ-024 A framing-error byte SHALL NOT affect parser state or the VAL timeout.

Reset
REQ-025 On rst high, asynchronously: tx=1, leds=0, all duty=0, all shadow=0, PWM counter=0, parser=IDX, receiver and transmitter idle, pending slot empty, synchroniser=1.
REQ-026 Reset asserted mid-frame or mid-transmission SHALL abandon the frame with no duty write; tx SHALL be 1 from reset assertion until a new response is queued.

Verification
(CLK_HZ=1000000, BAUD=100000, so 10 clk/bit; N_LEDS=24, PWM_BITS=8)
REQ-027 Bench SHALL cover: send 0x05, 0x80 -> ACK 0x06 on tx; from the next counter wrap, leds[5] high for exactly 128 of 256 clocks; other leds stay 0.
REQ-028 Bench SHALL cover: send 0xFF, 0xFF -> ACK; all 24 leds high 255 of 256 clocks; then send 0xFF, 0x00 -> all leds constantly 0.
REQ-029 Bench SHALL cover: send 0x30 -> NAK 0x15; parser remains in IDX, so a following 0x02, 0x40 lights leds[2] at 64/256.
REQ-030 Bench SHALL cover: send 0x03 only, idle 320 clk, then send 0x10 -> no write to channel 3; 0x10 is parsed as an index.
REQ-031 Bench SHALL cover: byte with stop bit 0 in VAL -> discarded, no ACK; a valid byte before the timeout still completes the write.
REQ-032 Bench SHALL cover: write 0x40 to channel 0 mid-period, then assert rst mid-frame -> output unchanged until wrap, then 64/256; after rst, leds=0, tx=1, and channel 0 duty=0.

Source files
------------

// File: rtl/led_pwm_uart.sv
// led_pwm_uart -- UART-controlled bank of PWM LED channels.
//
// The host sends two-byte commands over 8N1 UART: an index byte (channel
// number, or 0xFF for all channels) followed by a value byte. The low
// PWM_BITS bits of the value become the channel duty. A completed write is
// answered with ACK (0x06) and an unknown index with NAK (0x15). If the value
// byte does not arrive within 32 bit-times, the command is dropped silently.
// Duty changes take effect only at the next PWM period boundary.
//
// Ports
//   clk   : sole clock, rising edge
//   rst   : asynchronous active-high reset
//   rx    : UART receive, idle high, asynchronous to clk
//   tx    : UART transmit, idle high, registered
//   leds  : per-channel PWM output, 1 = lit

// One PWM channel: duty register, period-aligned shadow, registered output.
module led_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_i,
  input  logic [PWM_BITS-1:0] wdata_i,
  input  logic                wrap_i,   // counter is all-ones, wraps this edge
  input  logic [PWM_BITS-1:0] cnt_d_i,  // counter value after this edge
  output logic                led_o
);
  logic [PWM_BITS-1:0] duty_q, shadow_q, shadow_d;
  logic                led_q, led_d;

  // Compare against next-state values so led_q always equals
  // (shadow_q > cnt_q) in the same cycle.
  assign shadow_d = wrap_i ? duty_q : shadow_q;
  assign led_d    = shadow_d > cnt_d_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q   <= '0;
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      if (wr_i) duty_q <= wdata_i;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;
endmodule

module led_pwm_uart #(
  parameter int CLK_HZ   = 12000000,
  parameter int BAUD     = 115200,
  parameter int N_LEDS   = 24,
  parameter int PWM_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              tx,
  output logic [N_LEDS-1:0] leds
);
  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int TW   = $clog2(32 * CPB);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(32 * CPB - 1);
  localparam logic [7:0]    NL8     = 8'(N_LEDS);
  localparam logic [7:0]    ACK     = 8'h06;
  localparam logic [7:0]    NAK     = 8'h15;

  // ---------------- rx synchroniser + falling-edge detect ----------------
  logic rx_meta_q, rx_s_q, rx_prev_q, rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s_q;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
  rx_st_e          rs_q, rs_d;
  logic [CW-1:0]   rc_q, rc_d;
  logic [2:0]      rb_q, rb_d;
  logic [7:0]      rsh_q, rsh_d;
  logic            rx_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q  <= R_IDLE;
      rc_q  <= '0;
      rb_q  <= '0;
      rsh_q <= '0;
    end else begin
      rs_q  <= rs_d;
      rc_q  <= rc_d;
      rb_q  <= rb_d;
      rsh_q <= rsh_d;
    end
  end

  always_comb begin
    rs_d   = rs_q;
    rc_d   = rc_q;
    rb_d   = rb_q;
    rsh_d  = rsh_q;
    rx_vld = 1'b0;
    case (rs_q)
      R_IDLE: if (rx_fall) begin
        rs_d = R_START;
        rc_d = '0;
      end
      R_START: begin
        if (rc_q != HALF_M1) rc_d = rc_q + 1'b1;
        else if (rx_s_q) rs_d = R_IDLE;       // glitch, not a real start bit
        else begin
          rs_d = R_DATA;
          rc_d = '0;
          rb_d = '0;
        end
      end
      R_DATA: begin
        if (rc_q != CPB_M1) rc_d = rc_q + 1'b1;
        else begin
          rc_d  = '0;
          rsh_d = {rx_s_q, rsh_q[7:1]};
          if (rb_q == 3'd7) rs_d = R_STOP;
          else rb_d = rb_q + 3'd1;
        end
      end
      R_STOP: begin
        if (rc_q != CPB_M1) rc_d = rc_q + 1'b1;
        else begin
          rs_d   = R_IDLE;
          rx_vld = rx_s_q;                    // low stop bit drops the byte
        end
      end
    endcase
  end

  // ---------------- command parser ----------------
  typedef enum logic {P_IDX, P_VAL} ps_e;
  ps_e           ps_q, ps_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en, resp_vld;
  logic [7:0]    resp_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q  <= P_IDX;
      tgt_q <= '0;
      tmo_q <= '0;
    end else begin
      ps_q  <= ps_d;
      tgt_q <= tgt_d;
      tmo_q <= tmo_d;
    end
  end

  always_comb begin
    ps_d      = ps_q;
    tgt_d     = tgt_q;
    tmo_d     = tmo_q;
    wr_en     = 1'b0;
    resp_vld  = 1'b0;
    resp_byte = ACK;
    case (ps_q)
      P_IDX: if (rx_vld) begin
        if (rsh_q < NL8 || rsh_q == 8'hFF) begin
          tgt_d = rsh_q;
          ps_d  = P_VAL;
          tmo_d = '0;
        end else begin
          resp_vld  = 1'b1;
          resp_byte = NAK;
        end
      end
      P_VAL: begin
        if (rx_vld) begin
          wr_en    = 1'b1;
          resp_vld = 1'b1;
          ps_d     = P_IDX;
        end else if (tmo_q == TMO_M1) ps_d = P_IDX;
        else tmo_d = tmo_q + 1'b1;
      end
    endcase
  end

  // ---------------- transmitter with 1-deep pending slot ----------------
  typedef enum logic {T_IDLE, T_BUSY} tx_st_e;
  tx_st_e        ts_q, ts_d;
  logic [9:0]    tsh_q, tsh_d;
  logic [CW-1:0] tc_q, tc_d;
  logic [3:0]    tb_q, tb_d;
  logic          tx_q, tx_d;
  logic          pv_q, pv_d;
  logic [7:0]    pb_q, pb_d;
  logic          load;
  logic [7:0]    load_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q  <= T_IDLE;
      tsh_q <= '1;
      tc_q  <= '0;
      tb_q  <= '0;
      tx_q  <= 1'b1;
      pv_q  <= 1'b0;
      pb_q  <= '0;
    end else begin
      ts_q  <= ts_d;
      tsh_q <= tsh_d;
      tc_q  <= tc_d;
      tb_q  <= tb_d;
      tx_q  <= tx_d;
      pv_q  <= pv_d;
      pb_q  <= pb_d;
    end
  end

  always_comb begin
    ts_d   = ts_q;
    tsh_d  = tsh_q;
    tc_d   = tc_q;
    tb_d   = tb_q;
    tx_d   = tx_q;
    pv_d   = pv_q;
    pb_d   = pb_q;
    load   = 1'b0;
    load_b = resp_byte;
    case (ts_q)
      T_IDLE: load = resp_vld;
      T_BUSY: begin
        // a response arriving mid-frame parks in the slot, newest wins
        if (resp_vld) begin
          pv_d = 1'b1;
          pb_d = resp_byte;
        end
        if (tc_q != CPB_M1) tc_d = tc_q + 1'b1;
        else if (tb_q != 4'd9) begin
          tc_d  = '0;
          tb_d  = tb_q + 4'd1;
          tsh_d = {1'b1, tsh_q[9:1]};
          tx_d  = tsh_q[1];
        end else if (pv_q) begin
          load   = 1'b1;
          load_b = pb_q;
          pv_d   = resp_vld;
        end else if (resp_vld) begin
          load = 1'b1;
          pv_d = 1'b0;
        end else begin
          ts_d = T_IDLE;
          tx_d = 1'b1;
        end
      end
    endcase
    if (load) begin
      ts_d  = T_BUSY;
      tsh_d = {1'b1, load_b, 1'b0};
      tx_d  = 1'b0;
      tc_d  = '0;
      tb_d  = '0;
    end
  end

  assign tx = tx_q;

  // ---------------- PWM counter and channel lanes ----------------
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                wrap;

  assign cnt_d = cnt_q + 1'b1;
  assign wrap  = &cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_lane
    localparam logic [7:0] LI = 8'(i);
    logic lane_wr;
    assign lane_wr = wr_en && (tgt_q == LI || tgt_q == 8'hFF);
    led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (lane_wr),
      .wdata_i (rsh_q[PWM_BITS-1:0]),
      .wrap_i  (wrap),
      .cnt_d_i (cnt_d),
      .led_o   (leds[i])
    );
  end
endmodule

// File: tb/tb_led_pwm_uart.sv
// Directed bench for led_pwm_uart at 10 clocks per UART bit, 24 channels,
// 8-bit PWM. Duty expectations live in exp_duty[]; a tx monitor decodes
// response bytes into txq.
module tb_led_pwm_uart;
  localparam int NL = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          tx;
  logic [NL-1:0] leds;

  int         n_chk = 0;
  int         n_err = 0;
  int         exp_duty [NL];
  logic [7:0] txq [$];
  logic [7:0] mon_b;

  led_pwm_uart #(
    .CLK_HZ  (1000000),
    .BAUD    (100000),
    .N_LEDS  (NL),
    .PWM_BITS(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .tx   (tx),
    .leds (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // tx decoder: sample mid-bit, push each complete byte
  always begin
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      repeat (5) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (10) @(negedge clk);
        mon_b[k] = tx;
      end
      repeat (10) @(negedge clk);
      chk("tx_stop", {31'd0, tx}, 32'd1);
      txq.push_back(mon_b);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] exp);
    int t;
    t = 0;
    while (txq.size() == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (txq.size() == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk(tag, {24'd0, txq.pop_front()}, {24'd0, exp});
  endtask

  task automatic expect_none(input string tag);
    repeat (150) @(negedge clk);
    chk(tag, txq.size(), 32'd0);
  endtask

  // settle past a wrap, then count lit cycles over one full period
  task automatic measure(input string tag);
    int hi [NL];
    for (int i = 0; i < NL; i++) hi[i] = 0;
    repeat (260) @(negedge clk);
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) hi[i] += int'(leds[i]);
    end
    for (int i = 0; i < NL; i++)
      chk($sformatf("%s_led%0d", tag, i), hi[i], exp_duty[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, hi, lows;
    for (int i = 0; i < NL; i++) exp_duty[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_leds", leds, 32'd0);
    chk("rst_tx", tx, 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_leds", leds, 32'd0);
    chk("idle_tx", tx, 32'd1);

    // single channel at half duty
    send_byte(8'h05, 1'b1);
    send_byte(8'h80, 1'b1);
    expect_resp("ack_ch5", 8'h06);
    exp_duty[5] = 128;
    measure("ch5");

    // broadcast full then zero
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    expect_resp("ack_all_ff", 8'h06);
    for (int i = 0; i < NL; i++) exp_duty[i] = 255;
    measure("all_ff");
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    expect_resp("ack_all_00", 8'h06);
    for (int i = 0; i < NL; i++) exp_duty[i] = 0;
    measure("all_00");

    // bad index -> NAK, parser stays in IDX
    send_byte(8'h30, 1'b1);
    expect_resp("nak_30", 8'h15);
    send_byte(8'h02, 1'b1);
    send_byte(8'h40, 1'b1);
    expect_resp("ack_ch2", 8'h06);
    exp_duty[2] = 64;
    measure("ch2");

    // VAL timeout: 0x10 afterwards is an index, not a value for channel 3
    send_byte(8'h03, 1'b1);
    repeat (340) @(negedge clk);
    send_byte(8'h10, 1'b1);
    expect_none("idx_10_noresp");
    send_byte(8'h20, 1'b1);
    expect_resp("ack_ch16", 8'h06);
    exp_duty[16] = 32;
    measure("tmo");

    // framing error inside VAL is ignored, write still completes
    send_byte(8'h07, 1'b1);
    send_byte(8'h99, 1'b0);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("ferr_noack", lows, 32'd0);
    send_byte(8'h30, 1'b1);
    expect_resp("ack_ch7", 8'h06);
    chk("ferr_single_resp", txq.size(), 32'd0);
    exp_duty[7] = 48;
    measure("ferr");

    // channel 1 at full duty marks the wrap: it is dark only at count 255
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    expect_resp("ack_ch1", 8'h06);
    exp_duty[1] = 255;
    measure("ch1");

    t = 0;
    while (leds[1] && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("wrap_sync", {31'd0, leds[1]}, 32'd0);
    // lands the duty write near count 17 of the following period
    repeat (72) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b1);
    hi = 0;
    t = 0;
    while (leds[1] && t < 300) begin
      if (leds[0]) hi++;
      @(negedge clk);
      t++;
    end
    chk("ch0_hold_mid_period", hi, 32'd0);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (leds[0]) hi++;
    end
    chk("ch0_next_period", hi, 32'd64);
    expect_resp("ack_ch0", 8'h06);

    // reset in the middle of a value byte
    send_byte(8'h00, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (35) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_leds", leds, 32'd0);
    chk("midrst_tx", tx, 32'd1);
    repeat (3) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b0;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("postrst_tx_idle", lows, 32'd0);
    chk("postrst_noresp", txq.size(), 32'd0);
    for (int i = 0; i < NL; i++) exp_duty[i] = 0;
    measure("postrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
